// File: rtl/accel_fifo_responder_pkg.sv
// ----------------------------------------------------------------------------
// accel_fifo_responder_pkg
// Shared definitions for the accelerator-side FIFO responder.
//   DATA_W_DEFAULT : word width of the router data bus
//   DEPTH_DEFAULT  : entries per FIFO (power of two, >= 2)
//   cnt_width()    : occupancy counter width, $clog2(depth)+1, so that a
//                    full FIFO (count == depth) can be represented
//   is_pow2()      : depth legality check used at elaboration
// ----------------------------------------------------------------------------
package accel_fifo_responder_pkg;

  localparam int DATA_W_DEFAULT = 128;
  localparam int DEPTH_DEFAULT  = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(DEPTH_DEFAULT);

endpackage

// File: rtl/accel_fifo_responder_if.sv
// ----------------------------------------------------------------------------
// accel_fifo_responder_if
// Bundles the router bus, the accelerator port and the status flags of one
// accelerator FIFO responder.
//   slave  modport : the responder itself (accepts reqs, drives data/flags)
//   master modport : router controller + accelerator side
// Signals:
//   put_req/put_data          router -> to-FIFO push
//   get_req/get_data/get_valid router pop of from-FIFO, registered data
//   acc_rd_req/acc_rd_data/acc_rd_valid  accelerator pop of to-FIFO
//   acc_wr_req/acc_wr_data    accelerator push into from-FIFO
//   to_*/from_* empty/full/count  occupancy status
//   ovf_err/udf_err           sticky error flags
// ----------------------------------------------------------------------------
interface accel_fifo_responder_if
  import accel_fifo_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
);

  logic              put_req;
  logic [DATA_W-1:0] put_data;
  logic              get_req;
  logic [DATA_W-1:0] get_data;
  logic              get_valid;
  logic              acc_rd_req;
  logic [DATA_W-1:0] acc_rd_data;
  logic              acc_rd_valid;
  logic              acc_wr_req;
  logic [DATA_W-1:0] acc_wr_data;
  logic              to_empty;
  logic              to_full;
  logic              from_empty;
  logic              from_full;
  logic [CNT_W-1:0]  to_count;
  logic [CNT_W-1:0]  from_count;
  logic              ovf_err;
  logic              udf_err;

  modport slave (
    input  put_req, put_data, get_req, acc_rd_req, acc_wr_req, acc_wr_data,
    output get_data, get_valid, acc_rd_data, acc_rd_valid,
    output to_empty, to_full, from_empty, from_full, to_count, from_count,
    output ovf_err, udf_err
  );

  modport master (
    output put_req, put_data, get_req, acc_rd_req, acc_wr_req, acc_wr_data,
    input  get_data, get_valid, acc_rd_data, acc_rd_valid,
    input  to_empty, to_full, from_empty, from_full, to_count, from_count,
    input  ovf_err, udf_err
  );

endinterface

// File: rtl/accel_fifo_responder_sync_fifo.sv
// ----------------------------------------------------------------------------
// accel_fifo_responder_sync_fifo
// Single-clock FIFO with registered pop data and 1-cycle pop latency.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and word
//   pop              read request
//   pop_data         popped word, holds its value when pop_valid=0
//   pop_valid        pop_data valid for the cycle after an accepted pop
//   count            occupancy (0..DEPTH)
//   empty, full      decoded from the registered count
//   ovf, udf         one-cycle pulses: push while full / pop while empty
// Full and empty are judged on the registered count only, so a pop at
// count==DEPTH cannot make room for a same-cycle push and a push at count==0
// cannot feed a same-cycle pop.
// ----------------------------------------------------------------------------
module accel_fifo_responder_sync_fifo
  import accel_fifo_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       pop_valid,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("accel_fifo_responder_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign ovf     = push && full;
  assign udf     = pop && empty;

  // Storage has no reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Output register: data only updates on an accepted pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= do_pop;
      if (do_pop) begin
        pop_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/accel_fifo_responder.sv
// ----------------------------------------------------------------------------
// accel_fifo_responder
// Accelerator-side responder for the router data bus controller. Holds a
// to-accelerator FIFO (router put -> accelerator read) and a from-accelerator
// FIFO (accelerator write -> router get), publishes their status flags and
// collects sticky overflow/underflow errors from both.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    accel_fifo_responder_if.slave, all request/data/status signals
// ----------------------------------------------------------------------------
module accel_fifo_responder
  import accel_fifo_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  accel_fifo_responder_if.slave   bus
);

  logic to_ovf;
  logic to_udf;
  logic from_ovf;
  logic from_udf;
  logic ovf_err_q;
  logic udf_err_q;

  accel_fifo_responder_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_to_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.put_req),
    .push_data (bus.put_data),
    .pop       (bus.acc_rd_req),
    .pop_data  (bus.acc_rd_data),
    .pop_valid (bus.acc_rd_valid),
    .count     (bus.to_count),
    .empty     (bus.to_empty),
    .full      (bus.to_full),
    .ovf       (to_ovf),
    .udf       (to_udf)
  );

  accel_fifo_responder_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_from_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.acc_wr_req),
    .push_data (bus.acc_wr_data),
    .pop       (bus.get_req),
    .pop_data  (bus.get_data),
    .pop_valid (bus.get_valid),
    .count     (bus.from_count),
    .empty     (bus.from_empty),
    .full      (bus.from_full),
    .ovf       (from_ovf),
    .udf       (from_udf)
  );

  // Both FIFOs share one pair of error flags, held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_q | to_ovf | from_ovf;
      udf_err_q <= udf_err_q | to_udf | from_udf;
    end
  end

  assign bus.ovf_err = ovf_err_q;
  assign bus.udf_err = udf_err_q;

endmodule
